softmax_sum_accumulator: RTL and testbench

- Streaming, multi-beat successor to the 32-element softmax sum block.
- Accepts LANES Q4.12 signed elements per beat. Accumulates a frame of up to N_TOTAL elements over several beats.
- Emits one saturated unsigned Q6.26 sum per frame, with valid/ready handshakes on both sides.
- Sits between the exp stage and the reciprocal/normalise stage of the softmax pipeline.
- Adds lane masking, a signed/clamp mode, backpressure and frame-length checking.

---
 rtl/softmax_pkg.sv | 45 ++++
 rtl/softmax_sum_accumulator_lane_adder_tree.sv | 75 +++++++
 rtl/softmax_sum_accumulator.sv | 177 +++++++++++++++++
 tb/tb_softmax_sum_accumulator.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax sum pipeline.
// Holds the Q-format constants, FSM encoding, the per-beat side-band tag that
// travels alongside the partial sums, and the output saturation helper.
package softmax_pkg;

  // Q-format of the exp-stage elements (Q4.12) and of the emitted sum (Q6.26)
  localparam int unsigned Q_IN_FRAC  = 12;
  localparam int unsigned Q_OUT_FRAC = 26;

  // Width the saturation helper works at; wide enough for any legal ACC_W
  localparam int unsigned SAT_W = 64;

  // FSM encoding kept as plain constants so older blocks can share it
  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    ACCUM = ST_ACCUM,
    DRAIN = ST_DRAIN,
    HOLD  = ST_HOLD
  } state_t;

  // Side-band flags carried with each beat through the pipeline
  typedef struct packed {
    logic first;      // first beat of the frame: restart the accumulator
    logic frame_end;  // last beat of the frame
    logic len_err;    // frame length mismatch, meaningful with frame_end
  } beat_tag_t;

  // Clamp a signed accumulator into the unsigned range [0, 2^out_w - 1]
  function automatic logic [SAT_W-1:0] sat_unsigned(input logic signed [SAT_W-1:0] acc,
                                                    input int unsigned out_w);
    logic [SAT_W-1:0] max_v;
    max_v = (SAT_W'(1) << out_w) - SAT_W'(1);
    if (acc < 0) begin
      return '0;
    end
    if ($unsigned(acc) > max_v) begin
      return max_v;
    end
    return $unsigned(acc);
  endfunction

endpackage

// File: rtl/softmax_sum_accumulator_lane_adder_tree.sv
// Stage 1 of the softmax sum: converts LANES Q4.12 elements into the
// accumulator format (mask, optional negative clamp, sign-extend, align to
// the output fraction) and registers their adder-tree sum with the beat tag.
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_valid           beat transfers this cycle
//   i_clamp           frame mode: clamp negative elements to zero
//   i_tag             side-band flags of this beat
//   i_data, i_mask    packed elements (lane 0 in LSBs) and lane enables
//   o_valid, o_tag    registered beat valid and flags
//   o_sum             registered signed sum of the converted lanes
module lane_adder_tree
  import softmax_pkg::*;
#(
  parameter int unsigned LANES = 8,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned SHIFT = 14,
  parameter int unsigned ACC_W = 40
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic                    i_clamp,
  input  beat_tag_t               i_tag,
  input  logic [LANES*IN_W-1:0]   i_data,
  input  logic [LANES-1:0]        i_mask,
  output logic                    o_valid,
  output beat_tag_t               o_tag,
  output logic signed [ACC_W-1:0] o_sum
);

  logic signed [IN_W-1:0]  elem;
  logic signed [ACC_W-1:0] node [LANES];
  logic signed [ACC_W-1:0] sum_c;

  // Lane conversion followed by an in-place pairwise reduction
  always_comb begin
    elem  = '0;
    sum_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      node[i] = '0;
    end
    for (int i = 0; i < int'(LANES); i++) begin
      elem = i_data[i*int'(IN_W) +: IN_W];
      if (!i_mask[i] || (i_clamp && elem[IN_W-1])) begin
        node[i] = '0;
      end else begin
        node[i] = {{(ACC_W-IN_W){elem[IN_W-1]}}, elem} <<< SHIFT;
      end
    end
    // Each pass halves the live width; writes land only on indices already read
    for (int unsigned w = LANES / 2; w >= 1; w = w / 2) begin
      for (int unsigned i = 0; i < w; i++) begin
        node[i] = node[2*i] + node[2*i+1];
      end
    end
    sum_c = node[0];
  end

  // Stage 1 register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_tag   <= '0;
      o_sum   <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_tag <= i_tag;
        o_sum <= sum_c;
      end
    end
  end

endmodule

// File: rtl/softmax_sum_accumulator.sv
// Streaming softmax denominator: accumulates a frame of up to N_TOTAL Q4.12
// exp values, LANES per beat, and emits one saturated unsigned Q6.26 sum per
// frame with a frame-length error flag. Valid/ready on both sides; one frame
// in flight at a time.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_clamp_neg           frame mode (sampled on the first beat): clamp negatives
//   i_valid, o_ready      input beat handshake
//   i_data, i_mask        packed signed elements (lane 0 in LSBs), lane enables
//   i_last                final beat of the frame
//   o_valid, i_out_ready  result handshake
//   o_sum                 saturated Q6.26 sum
//   o_len_err             frame length mismatch, qualified by o_valid
module softmax_sum_accumulator
  import softmax_pkg::*;
#(
  parameter int unsigned N_TOTAL  = 64,
  parameter int unsigned LANES    = 8,
  parameter int unsigned IN_W     = 16,
  parameter int unsigned IN_FRAC  = Q_IN_FRAC,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned OUT_FRAC = Q_OUT_FRAC
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clamp_neg,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [LANES*IN_W-1:0] i_data,
  input  logic [LANES-1:0]      i_mask,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  i_out_ready,
  output logic [OUT_W-1:0]      o_sum,
  output logic                  o_len_err
);

  localparam int unsigned SHIFT = OUT_FRAC - IN_FRAC;
  localparam int unsigned BEATS = N_TOTAL / LANES;
  localparam int unsigned ACC_W = OUT_W + $clog2(N_TOTAL) + 2;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  state_t                  state_q, state_d;
  logic                    ready_d, valid_d, load_out_c;
  logic [CNT_W-1:0]        beat_cnt_q;
  logic                    mode_q;
  logic                    xfer_c, first_c, at_max_c, frame_end_c, clamp_c;
  beat_tag_t               tag_c;

  logic                    s1_valid;
  beat_tag_t               s1_tag;
  logic signed [ACC_W-1:0] s1_sum;

  logic signed [ACC_W-1:0] acc_q, acc_base_c;
  logic                    s2_done_q, s2_err_q;

  // Beat classification for the accepted input
  always_comb begin
    xfer_c      = i_valid && o_ready;
    first_c     = (beat_cnt_q == '0);
    at_max_c    = (beat_cnt_q == CNT_W'(BEATS - 1));
    frame_end_c = i_last || at_max_c;
    // Mode is live on the first beat and latched for the rest of the frame
    clamp_c     = first_c ? i_clamp_neg : mode_q;
    tag_c.first     = first_c;
    tag_c.frame_end = frame_end_c;
    tag_c.len_err   = (i_last != at_max_c);
  end

  // Beat counter and latched frame mode
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_cnt_q <= '0;
      mode_q     <= 1'b0;
    end else if (xfer_c) begin
      beat_cnt_q <= frame_end_c ? '0 : beat_cnt_q + CNT_W'(1);
      if (first_c) begin
        mode_q <= i_clamp_neg;
      end
    end
  end

  // Stage 1: conversion and lane sum
  lane_adder_tree #(
    .LANES (LANES),
    .IN_W  (IN_W),
    .SHIFT (SHIFT),
    .ACC_W (ACC_W)
  ) u_tree (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (xfer_c),
    .i_clamp (clamp_c),
    .i_tag   (tag_c),
    .i_data  (i_data),
    .i_mask  (i_mask),
    .o_valid (s1_valid),
    .o_tag   (s1_tag),
    .o_sum   (s1_sum)
  );

  always_comb begin
    acc_base_c = s1_tag.first ? '0 : acc_q;
  end

  // Stage 2: frame accumulator; s2_done_q pulses once the frame's last beat is in
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q     <= '0;
      s2_done_q <= 1'b0;
      s2_err_q  <= 1'b0;
    end else begin
      s2_done_q <= s1_valid && s1_tag.frame_end;
      if (s1_valid) begin
        acc_q <= acc_base_c + s1_sum;
        if (s1_tag.frame_end) begin
          s2_err_q <= s1_tag.len_err;
        end
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    ready_d    = 1'b0;
    valid_d    = o_valid;
    load_out_c = 1'b0;
    case (state_q)
      ACCUM: begin
        ready_d = 1'b1;
        if (xfer_c && frame_end_c) begin
          state_d = DRAIN;
          ready_d = 1'b0;
        end
      end
      DRAIN: begin
        if (s2_done_q) begin
          load_out_c = 1'b1;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (i_out_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ACCUM;
      o_ready   <= 1'b0;
      o_valid   <= 1'b0;
      o_sum     <= '0;
      o_len_err <= 1'b0;
    end else begin
      state_q <= state_d;
      o_ready <= ready_d;
      o_valid <= valid_d;
      if (load_out_c) begin
        o_sum     <= OUT_W'(sat_unsigned(SAT_W'(acc_q), OUT_W));
        o_len_err <= s2_err_q;
      end
    end
  end

endmodule

// File: tb/tb_softmax_sum_accumulator.sv
// Directed bench for softmax_sum_accumulator (LANES=8, N_TOTAL=64, Q4.12 -> Q6.26).
module tb_softmax_sum_accumulator;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_clamp_neg;
  logic        i_valid;
  logic        o_ready;
  logic [127:0] i_data;
  logic [7:0]  i_mask;
  logic        i_last;
  logic        o_valid;
  logic        i_out_ready;
  logic [31:0] o_sum;
  logic        o_len_err;

  int tests = 0;
  int fails = 0;

  softmax_sum_accumulator dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clamp_neg (i_clamp_neg),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_mask      (i_mask),
    .i_last      (i_last),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_sum       (o_sum),
    .o_len_err   (o_len_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One accepted beat: lanes 0-3 carry lo, lanes 4-7 carry hi
  task automatic beat(input logic [15:0] lo, input logic [15:0] hi, input logic [7:0] m,
                      input logic last, input logic clamp);
    int n = 0;
    i_valid     = 1'b1;
    i_data      = {hi, hi, hi, hi, lo, lo, lo, lo};
    i_mask      = m;
    i_last      = last;
    i_clamp_neg = clamp;
    while (o_ready !== 1'b1 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 50) check("beat_accept_timeout", 64'(o_ready), 64'(1));
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic frame(input logic [15:0] d, input logic [7:0] m, input int nb,
                       input logic last_end, input logic clamp);
    for (int b = 0; b < nb; b++) beat(d, d, m, last_end && (b == nb - 1), clamp);
  endtask

  // Beat 1 mixes lo/hi lanes, then seven zero beats close the frame
  task automatic mixed(input logic clamp, input logic [15:0] lo, input logic [15:0] hi);
    beat(lo, hi, 8'hFF, 1'b0, clamp);
    for (int b = 0; b < 7; b++) beat(16'h0000, 16'h0000, 8'hFF, b == 6, clamp);
  endtask

  task automatic expect_result(input string tag, input logic [31:0] exp_sum, input logic exp_err);
    int n = 0;
    while (o_valid !== 1'b1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check({tag, "_valid"}, 64'(o_valid), 64'(1));
    check({tag, "_sum"}, 64'(o_sum), 64'(exp_sum));
    check({tag, "_err"}, 64'(o_len_err), 64'(exp_err));
    i_out_ready = 1'b1;
    @(negedge i_clk);
    i_out_ready = 1'b0;
    check({tag, "_handshake"}, 64'({o_valid, o_ready}), 64'(2'b01));
  endtask

  initial begin
    logic saw_valid;
    int   n;
    i_rst = 1'b1; i_clamp_neg = 1'b1; i_valid = 1'b0; i_data = '0;
    i_mask = '0; i_last = 1'b0; i_out_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_ready", 64'(o_ready), 64'(0));
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_sum", 64'(o_sum), 64'(0));
    check("rst_err", 64'(o_len_err), 64'(0));
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_rst_ready", 64'(o_ready), 64'(1));

    // Full frame of 1.0: 64.0 saturates; o_valid three cycles after the last beat
    frame(16'h1000, 8'hFF, 8, 1'b1, 1'b1);
    check("lat_t1", 64'({o_valid, o_ready}), 64'(2'b00));
    @(negedge i_clk);
    check("lat_t2", 64'(o_valid), 64'(0));
    @(negedge i_clk);
    check("lat_t3", 64'(o_valid), 64'(1));
    expect_result("full_one", 32'hFFFF_FFFF, 1'b0);

    // Half values: 32.0, then only four lanes enabled: 16.0
    frame(16'h0800, 8'hFF, 8, 1'b1, 1'b1);
    expect_result("half", 32'h8000_0000, 1'b0);
    frame(16'h0800, 8'h0F, 8, 1'b1, 1'b1);
    expect_result("half_mask", 32'h4000_0000, 1'b0);

    // Four +1.0 and four -1.0 lanes: clamp gives 4.0, signed gives 0
    mixed(1'b1, 16'h1000, 16'hF000);
    expect_result("clamp_mix", 32'h1000_0000, 1'b0);
    mixed(1'b0, 16'h1000, 16'hF000);
    expect_result("signed_mix", 32'h0000_0000, 1'b0);
    mixed(1'b0, 16'hF000, 16'hF000);
    expect_result("signed_neg", 32'h0000_0000, 1'b0);

    // Short frame (last on beat 3) and full-length frame missing its last flag
    frame(16'h1000, 8'hFF, 3, 1'b1, 1'b1);
    expect_result("short", 32'h6000_0000, 1'b1);
    frame(16'h0100, 8'hFF, 8, 1'b0, 1'b1);
    expect_result("no_last", 32'h1000_0000, 1'b1);

    // Backpressure: result held while a next-frame beat is offered
    frame(16'h0800, 8'h0F, 8, 1'b1, 1'b1);
    n = 0;
    while (o_valid !== 1'b1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    i_valid = 1'b1; i_data = {8{16'h1000}}; i_mask = 8'hFF; i_last = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("bp_hold", 64'({o_valid, o_ready, o_sum}), {30'd0, 2'b10, 32'h4000_0000});
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    expect_result("bp", 32'h4000_0000, 1'b0);

    // Bubbled frame: masked beat 3, a negative beat 5, mode change after beat 1 ignored
    for (int b = 0; b < 8; b++) begin
      beat((b == 4) ? 16'hFC00 : 16'h0400, (b == 4) ? 16'hFC00 : 16'h0400,
           (b == 2) ? 8'h00 : 8'hFF, b == 7, b != 0);
      if (b != 7) repeat (2) @(negedge i_clk);
    end
    expect_result("bubble", 32'h2800_0000, 1'b0);

    // Reset after four beats discards the frame and clears outputs at once
    frame(16'h1000, 8'hFF, 4, 1'b0, 1'b1);
    i_rst = 1'b1;
    #1;
    check("midrst_out", 64'({o_valid, o_ready, o_len_err, o_sum}), 64'(0));
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) saw_valid = 1'b1;
    end
    check("midrst_no_valid", 64'(saw_valid), 64'(0));
    check("midrst_ready", 64'(o_ready), 64'(1));
    frame(16'h0800, 8'hFF, 8, 1'b1, 1'b1);
    expect_result("after_rst", 32'h8000_0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
